// File: rtl/fp_core_pkg.sv
// Shared fp_core definitions: rounding-mode encoding and signed full-scale helpers.
package fp_core_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC      = 2'd0,
        RND_HALF_UP    = 2'd1,
        RND_CONVERGENT = 2'd2,
        RND_RSVD       = 2'd3
    } round_mode_t;

    // Largest / smallest two's-complement value representable in w bits.
    function automatic longint fs_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint fs_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/round_shift_signed.sv
// Combinational signed right shift by SHIFT with TRUNC / HALF_UP / CONVERGENT rounding.
module round_shift_signed
    import fp_core_pkg::*;
#(
    parameter int INW   = 32,
    parameter int SHIFT = 8
) (
    input  logic [INW-1:0]   din,
    input  round_mode_t      mode,
    output logic [INW-SHIFT:0] dout
);

    generate
        if (SHIFT == 0) begin : g_pass
            logic unused_mode;
            assign unused_mode = ^mode;
            assign dout = {din[INW-1], din};
        end else begin : g_rnd
            localparam int W = INW - SHIFT + 1;
            localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);

            logic [W-1:0]     flr;
            logic [SHIFT-1:0] frac;
            logic             bump;

            // Rounding up by one LSB of the result is equivalent to adding half an LSB
            // at full precision; the one-bit headroom in W keeps max-positive from wrapping.
            always_comb begin
                flr  = {din[INW-1], din[INW-1:SHIFT]};
                frac = din[SHIFT-1:0];
                bump = 1'b0;
                case (mode)
                    RND_HALF_UP:    bump = (frac >= HALF);
                    RND_CONVERGENT: bump = (frac > HALF) || ((frac == HALF) && flr[0]);
                    default:        bump = 1'b0;
                endcase
                dout = flr + W'(bump);
            end
        end
    endgenerate

endmodule

// File: rtl/round_clip_signed_pipe.sv
// Multi-lane two-stage word-length reducer: shift+round, then saturate, with clip-event counter.
module round_clip_signed_pipe
    import fp_core_pkg::*;
#(
    parameter int INW   = 32,
    parameter int OUTW  = 16,
    parameter int SHIFT = 8,
    parameter int LANES = 2,
    parameter int CNTW  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [LANES*INW-1:0]    s_data,
    input  logic [1:0]              s_mode,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LANES*OUTW-1:0]   m_data,
    output logic [LANES-1:0]        m_clip,
    output logic [CNTW-1:0]         sat_count,
    input  logic                    sat_clear
);

    localparam int W1 = INW - SHIFT + 1;
    localparam logic signed [W1-1:0] LIM_HI = W1'(fs_max(OUTW));
    localparam logic signed [W1-1:0] LIM_LO = W1'(fs_min(OUTW));
    localparam logic [OUTW-1:0]      OUT_HI = OUTW'(fs_max(OUTW));
    localparam logic [OUTW-1:0]      OUT_LO = OUTW'(fs_min(OUTW));

    generate
        if (SHIFT < 0 || SHIFT > INW - OUTW) begin : g_bad_shift
            $error("round_clip_signed_pipe: SHIFT must be in 0..INW-OUTW");
        end
        if (OUTW < 2) begin : g_bad_outw
            $error("round_clip_signed_pipe: OUTW must be >= 2");
        end
        if (LANES < 1) begin : g_bad_lanes
            $error("round_clip_signed_pipe: LANES must be >= 1");
        end
    endgenerate

    round_mode_t                 mode_in;
    logic [LANES-1:0][W1-1:0]    rnd;

    assign mode_in = round_mode_t'(s_mode);

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            round_shift_signed #(.INW(INW), .SHIFT(SHIFT)) u_rnd (
                .din  (s_data[i*INW +: INW]),
                .mode (mode_in),
                .dout (rnd[i])
            );
        end
    endgenerate

    logic                      st1_valid_q, st1_valid_d;
    logic [LANES-1:0][W1-1:0]  st1_val_q, st1_val_d;
    logic                      m_valid_q, m_valid_d;
    logic [LANES*OUTW-1:0]     m_data_q, m_data_d;
    logic [LANES-1:0]          m_clip_q, m_clip_d;
    logic [CNTW-1:0]           sat_count_q, sat_count_d;

    logic                      st2_load;
    logic                      out_hs;
    logic [CNTW:0]             clip_inc;
    logic [CNTW:0]             cnt_sum;

    // Handshake: a beat transfers on a port when valid && ready are both high at the
    // rising edge; valid never waits on ready, and payload holds while valid && !ready.
    // Each stage loads when empty or when its current beat leaves this cycle.
    always_comb begin
        st1_valid_d = st1_valid_q;
        st1_val_d   = st1_val_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_clip_d    = m_clip_q;
        sat_count_d = sat_count_q;
        clip_inc    = '0;

        st2_load = !m_valid_q || m_ready;
        s_ready  = !st1_valid_q || st2_load;
        out_hs   = m_valid_q && m_ready;

        if (s_ready) begin
            st1_valid_d = s_valid;
            if (s_valid) begin
                st1_val_d = rnd;
            end
        end

        if (st2_load) begin
            m_valid_d = st1_valid_q;
            if (st1_valid_q) begin
                for (int i = 0; i < LANES; i++) begin
                    if ($signed(st1_val_q[i]) > LIM_HI) begin
                        m_data_d[i*OUTW +: OUTW] = OUT_HI;
                        m_clip_d[i]              = 1'b1;
                    end else if ($signed(st1_val_q[i]) < LIM_LO) begin
                        m_data_d[i*OUTW +: OUTW] = OUT_LO;
                        m_clip_d[i]              = 1'b1;
                    end else begin
                        m_data_d[i*OUTW +: OUTW] = st1_val_q[i][OUTW-1:0];
                        m_clip_d[i]              = 1'b0;
                    end
                end
            end
        end

        for (int i = 0; i < LANES; i++) begin
            clip_inc = clip_inc + (CNTW+1)'(m_clip_q[i]);
        end
        cnt_sum = {1'b0, sat_count_q} + clip_inc;

        // Clear wins over a same-cycle increment; the count pins at all-ones.
        if (sat_clear) begin
            sat_count_d = '0;
        end else if (out_hs) begin
            sat_count_d = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st1_valid_q <= 1'b0;
            st1_val_q   <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_clip_q    <= '0;
            sat_count_q <= '0;
        end else begin
            st1_valid_q <= st1_valid_d;
            st1_val_q   <= st1_val_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_clip_q    <= m_clip_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_clip    = m_clip_q;
    assign sat_count = sat_count_q;

endmodule
